// File: rtl/gray_pkg.sv
// Shared Gray-code helpers: speed encodings for the prefix network and Gray/binary conversion.
// Latency: none (constants and pure functions only).
// Backpressure: not applicable.
package gray_pkg;

  // Prefix-structure selectors for the lowest-set-bit search
  localparam int SpeedSlow   = 0;  // serial ripple chain
  localparam int SpeedMedium = 1;  // Brent-Kung
  localparam int SpeedFast   = 2;  // Sklansky

  // Conversions operate on a fixed wide word; narrower values are zero-extended,
  // which leaves the converted result zero-extended as well.
  localparam int MaxWidth = 64;

  function automatic logic [MaxWidth-1:0] gray_to_bin(input logic [MaxWidth-1:0] g);
    logic [MaxWidth-1:0] b;
    b[MaxWidth-1] = g[MaxWidth-1];
    for (int i = MaxWidth - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [MaxWidth-1:0] bin_to_gray(input logic [MaxWidth-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gray_dec.sv
// Combinational reflected-Gray decrementer: a -> z (one step backwards) plus a wrap flag at zero.
// Latency: zero cycles, purely combinational.
// Backpressure: none; the caller decides whether to register z.
module gray_dec
  import gray_pkg::*;
#(
  parameter int width = 16,
  parameter int speed = SpeedMedium
) (
  input  logic [width-1:0] a,
  output logic [width-1:0] z,
  output logic             wrap
);

  localparam int Levels = $clog2(width);

  logic             parity;
  logic             is_zero;
  logic [width-1:0] nz;
  logic [width-1:0] pre_incl;  // pre_incl[i] = all of a[i:0] are zero
  logic [width-1:0] pre_excl;  // pre_excl[i] = all of a[i-1:0] are zero
  logic [width-1:0] lsb;       // one-hot lowest set bit of a
  logic [width-1:0] flip;

  // Odd parity means the predecessor differs only in bit 0
  assign parity = ^a;
  assign nz     = ~a;

  // Inclusive prefix-AND over ~a, network shape chosen by speed
  always_comb begin
    pre_incl = nz;
    if (speed == SpeedSlow) begin
      for (int i = 1; i < width; i++) begin
        pre_incl[i] = pre_incl[i] & pre_incl[i-1];
      end
    end else if (speed == SpeedFast) begin
      for (int l = 0; l < Levels; l++) begin
        for (int i = 0; i < width; i++) begin
          if (((i >> l) & 1) == 1) begin
            pre_incl[i] = pre_incl[i] & pre_incl[((i >> l) << l) - 1];
          end
        end
      end
    end else begin
      // Brent-Kung: up-sweep builds power-of-two spans, down-sweep fills the gaps
      for (int l = 0; l < Levels; l++) begin
        for (int i = 0; i < width; i++) begin
          if (((i + 1) % (2 ** (l + 1))) == 0) begin
            pre_incl[i] = pre_incl[i] & pre_incl[i - 2 ** l];
          end
        end
      end
      for (int l = Levels - 1; l >= 0; l--) begin
        for (int i = 0; i < width; i++) begin
          if ((i >= 2 ** (l + 1)) && (((i + 1) % (2 ** (l + 1))) == 2 ** l)) begin
            pre_incl[i] = pre_incl[i] & pre_incl[i - 2 ** l];
          end
        end
      end
    end
  end

  // The top of the inclusive prefix doubles as the all-zero detector
  assign is_zero  = pre_incl[width-1];
  assign pre_excl = {pre_incl[width-2:0], 1'b1};
  assign lsb      = a & pre_excl;

  // Pick the single bit to toggle; even parity with a non-zero word never has
  // its lowest set bit at the MSB, so shifting lsb up cannot lose a bit
  always_comb begin
    flip = '0;
    if (parity) begin
      flip[0] = 1'b1;
    end else if (is_zero) begin
      flip[width-1] = 1'b1;
    end else begin
      flip = lsb << 1;
    end
  end

  assign z    = a ^ flip;
  assign wrap = is_zero;

endmodule

// File: rtl/gray_dec_counter.sv
// Registered Gray down-counter with binary view, zero flag and wrap/underflow pulse.
// Latency: inputs sampled at an edge appear on all outputs right after that edge.
// Backpressure: none; every en_i cycle decrements (or saturates) unconditionally.
module gray_dec_counter
  import gray_pkg::*;
#(
  parameter int width    = 16,  // 2..64
  parameter int speed    = SpeedMedium,
  parameter bit Saturate = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [width-1:0] load_val_i,
  input  logic             en_i,
  output logic [width-1:0] count_o,
  output logic [width-1:0] bin_o,
  output logic             zero_o,
  output logic             wrap_o
);

  logic [width-1:0] dec_gray;
  logic [width-1:0] dec_bin;
  logic [width-1:0] load_bin;
  logic             dec_wrap;

  gray_dec #(
    .width(width),
    .speed(speed)
  ) u_dec (
    .a   (count_o),
    .z   (dec_gray),
    .wrap(dec_wrap)
  );

  // Binary views are derived from the Gray value being registered, so the two never disagree
  assign dec_bin  = width'(gray_to_bin(MaxWidth'(dec_gray)));
  assign load_bin = width'(gray_to_bin(MaxWidth'(load_val_i)));

  // Count state with priority reset > clear > load > decrement > hold
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_o <= '0;
      bin_o   <= '0;
      zero_o  <= 1'b1;
      wrap_o  <= 1'b0;
    end else if (clr_i) begin
      count_o <= '0;
      bin_o   <= '0;
      zero_o  <= 1'b1;
      wrap_o  <= 1'b0;
    end else if (load_i) begin
      count_o <= load_val_i;
      bin_o   <= load_bin;
      zero_o  <= (load_val_i == '0);
      wrap_o  <= 1'b0;
    end else if (en_i) begin
      if (dec_wrap && Saturate) begin
        // Underflow while saturating: stay at zero but still flag the event
        wrap_o <= 1'b1;
      end else begin
        count_o <= dec_gray;
        bin_o   <= dec_bin;
        zero_o  <= (dec_gray == '0);
        wrap_o  <= dec_wrap;
      end
    end else begin
      wrap_o <= 1'b0;
    end
  end

endmodule
